mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the single shared instruction/data memory port. It accepts fetch requests from the PC stage and load/store requests from the datapath. It serialises them onto one memory address/write port with a fixed 3-cycle transaction, and returns read data, acknowledge and error per requester. Data accesses have priority over fetches, and a starvation counter guarantees fetch progress.

## Interface
Parameters:
- ADDR_W, 32, width of all byte addresses
- DATA_W, 32, word width
- DEPTH_WORDS, 64, number of valid memory words; word index is addr[ADDR_W-1:2]
- STARVE_MAX, 4, consecutive lost fetch arbitrations before fetch is forced to win

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch byte address (PC)
- if_ack  out  1  one-cycle fetch completion pulse
- if_err  out  1  valid with if_ack; misaligned or out-of-range fetch
- if_rdata  out  DATA_W  fetched instruction, valid with if_ack, held until next if_ack
- dm_req  in  1  data request, held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data byte address
- dm_wdata  in  DATA_W  store data
- dm_ack  out  1  one-cycle data completion pulse
- dm_err  out  1  valid with dm_ack; misaligned or out-of-range access
- dm_rdata  out  DATA_W  load data, valid with dm_ack, held until next dm_ack
- mem_addr  out  ADDR_W  address to memory; drives the instruction, load and store address inputs together
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  combinational read data from memory at mem_addr
- busy  out  1  high in ACCESS and RESP

## Operation
- FSM states: IDLE, ACCESS, RESP. There are no other states; unreachable encodings go to IDLE.
- IDLE: requests are sampled.
  - Only dm_req: grant data.
  - Only if_req: grant fetch.
  - Both requests with starve_cnt < STARVE_MAX: grant data and increment starve_cnt.
  - Both requests with starve_cnt == STARVE_MAX: grant fetch.
  - Any fetch grant clears starve_cnt. starve_cnt saturates at STARVE_MAX.
  - On a grant, latch the requester id, addr, we (forced 0 for fetch) and wdata. Latch err = (addr[1:0] != 0) or (addr[ADDR_W-1:2] >= DEPTH_WORDS). Go to ACCESS. With no request, stay in IDLE.
- ACCESS:
  - mem_addr = latched addr.
  - mem_wdata = latched wdata.
  - mem_we = latched we AND NOT latched err.
  - On the closing edge, capture mem_rdata into the granted side's rdata register. Capture 0 if err, and also 0 for a store. Set that side's ack and err. Go to RESP.
- RESP: the granted side's ack is high for this cycle only. Go to IDLE.
- Outside ACCESS: mem_addr = 0, mem_we = 0, mem_wdata = 0.
- Erroneous accesses never write memory. They still complete with ack = 1 and err = 1.
- The requester not granted is not acknowledged. Its request is re-arbitrated in the next IDLE.

## Timing
- Request high in cycle 0 with FSM in IDLE: grant edge ends cycle 0, ACCESS is cycle 1, ack is high in cycle 2, IDLE is cycle 3.
- Minimum transaction spacing is 3 cycles.
- Requesters drop req, or change address, in the cycle after ack. If req is still high in IDLE, it is treated as a new request.
- A store commits on the rising edge ending ACCESS, when memory samples mem_we.
- A load issued after a store returns the stored value, because the transactions are strictly serial.
- Address and data inputs need only be stable in the IDLE cycle where the grant occurs. They are latched there.
- Reset (rst = 0) takes effect immediately and asynchronously:
  - State goes to IDLE, starve_cnt = 0, latches are cleared.
  - if_ack, dm_ack, if_err, dm_err, busy, mem_we = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
- Reset during ACCESS aborts the transaction. No write occurs because mem_we drops asynchronously, and no ack is issued.
- After reset is released, the first arbitration happens on the first IDLE edge.

## Test plan
- Single fetch: memory word 3 = 32'hDEADBEEF, if_req with if_addr = 0x0C in cycle 0. Required: mem_addr = 0x0C in cycle 1; if_ack = 1, if_rdata = DEADBEEF, if_err = 0 in cycle 2; busy low in cycle 3.
- Store then load: dm_we = 1, dm_addr = 0x10, dm_wdata = 0x12345678. Required: mem_we = 1 for exactly one cycle. Then a load from 0x10 returns dm_rdata = 0x12345678 with dm_ack.
- Contention and starvation: hold if_req and dm_req continuously, with STARVE_MAX = 4. Required grant order D, D, D, D, F, D, D, D, D, F. Each ack is spaced 3 cycles apart.
- Errors: dm store to 0x11, then fetch from 0x100 (word 64). Required: dm_ack = 1, dm_err = 1, mem_we stays 0, word 4 unchanged. Then if_ack = 1, if_err = 1, if_rdata = 0.
- Async reset mid-store: assert rst = 0 in the middle of the ACCESS cycle of a store to 0x20. Required: mem_we falls immediately, target word unchanged, no dm_ack. All outputs 0 until release. A repeated store after release completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shared instruction/data memory port arbiter: data-first arbitration with a
// starvation guard for fetches, one fixed IDLE -> ACCESS -> RESP transaction at a time.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic              dm_err,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_nxt;
  logic              gnt_any, gnt_dm;
  logic              sel_dm;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_err;

  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS));
  endfunction

  // Stores and faulted accesses return zero read data.
  function automatic logic [DATA_W-1:0] rd_mask(input logic [DATA_W-1:0] d,
                                                input logic we, input logic err);
    return (we || err) ? '0 : d;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    gnt_any    = 1'b0;
    gnt_dm     = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req && (!if_req || (starve_cnt < SMAX))) begin
          gnt_any   = 1'b1;
          gnt_dm    = 1'b1;
          state_nxt = ACCESS;
          if (if_req) starve_nxt = starve_cnt + CNT_W'(1);
        end else if (if_req) begin
          gnt_any    = 1'b1;
          state_nxt  = ACCESS;
          starve_nxt = '0;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant stage: capture the winning request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_dm    <= 1'b0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_err   <= 1'b0;
    end else if (gnt_any) begin
      sel_dm    <= gnt_dm;
      lat_addr  <= gnt_dm ? dm_addr : if_addr;
      lat_we    <= gnt_dm & dm_we;
      lat_wdata <= gnt_dm ? dm_wdata : '0;
      lat_err   <= addr_err(gnt_dm ? dm_addr : if_addr);
    end
  end

  // Response stage: close ACCESS into the granted side's result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_ack   <= 1'b0;
      if_err   <= 1'b0;
      if_rdata <= '0;
      dm_ack   <= 1'b0;
      dm_err   <= 1'b0;
      dm_rdata <= '0;
    end else begin
      if_ack <= 1'b0;
      if_err <= 1'b0;
      dm_ack <= 1'b0;
      dm_err <= 1'b0;
      if (state == ACCESS) begin
        if (sel_dm) begin
          dm_ack   <= 1'b1;
          dm_err   <= lat_err;
          dm_rdata <= rd_mask(mem_rdata, lat_we, lat_err);
        end else begin
          if_ack   <= 1'b1;
          if_err   <= lat_err;
          if_rdata <= rd_mask(mem_rdata, 1'b0, lat_err);
        end
      end
    end
  end

  // Memory drive is decoded from state so reset removes mem_we immediately.
  assign mem_addr  = (state == ACCESS) ? lat_addr : '0;
  assign mem_wdata = (state == ACCESS) ? lat_wdata : '0;
  assign mem_we    = (state == ACCESS) && lat_we && !lat_err;
  assign busy      = (state == ACCESS) || (state == RESP);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 64-word memory and
// a queue of expected responses popped at each acknowledge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack, if_err;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ack, dm_err;
  logic [31:0] dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, busy;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(64), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_err(dm_err), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 3) ? 32'hDEADBEEF : (32'hA000_0000 | 32'(i));
  endfunction

  logic [31:0] mem [0:63];
  logic        mem_loaded = 1'b0;
  logic        in_range;
  assign in_range  = (mem_addr[31:8] == 24'h0);
  assign mem_rdata = in_range ? mem[mem_addr[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (mem_we && in_range) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  typedef struct {
    bit          dm;
    bit          err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  int last_cyc;
  int last_we;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit dm, input bit err, input logic [31:0] rdata);
    exp_t e;
    e.dm = dm; e.err = err; e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Wait (bounded) for an acknowledge, then compare it against the queue head.
  task automatic wait_resp(input string tag);
    bit   got = 1'b0;
    exp_t e;
    last_cyc = 0;
    last_we  = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      last_cyc++;
      if (mem_we) last_we++;
      if (if_ack || dm_ack) got = 1'b1;
    end
    chk1({tag, "_ack_seen"}, got, 1'b1);
    if (got) begin
      chk1({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk1({tag, "_side_dm"}, dm_ack, e.dm);
        chk1({tag, "_side_if"}, if_ack, !e.dm);
        chk1({tag, "_err"}, e.dm ? dm_err : if_err, e.err);
        chk32({tag, "_rdata"}, e.dm ? dm_rdata : if_rdata, e.rdata);
      end
    end
  endtask

  task automatic run_txn(input string tag, input bit dm, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit exp_err, input logic [31:0] exp_rd);
    push_exp(dm, exp_err, exp_rd);
    if (dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    wait_resp(tag);
    chk32({tag, "_latency"}, 32'(last_cyc), 32'd2);
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk1("rst_if_ack", if_ack, 1'b0);
    chk1("rst_dm_ack", dm_ack, 1'b0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Single fetch, cycle by cycle.
    push_exp(1'b0, 1'b0, 32'hDEADBEEF);
    if_req = 1'b1; if_addr = 32'h0C;
    @(negedge clk);
    chk32("f1_mem_addr", mem_addr, 32'h0C);
    chk1("f1_busy_c1", busy, 1'b1);
    chk1("f1_we_c1", mem_we, 1'b0);
    chk1("f1_noack_c1", if_ack, 1'b0);
    wait_resp("f1");
    chk32("f1_latency", 32'(last_cyc), 32'd1);
    if_req = 1'b0;
    @(negedge clk);
    chk1("f1_busy_c3", busy, 1'b0);
    chk1("f1_ack_c3", if_ack, 1'b0);
    chk32("f1_rdata_held", if_rdata, 32'hDEADBEEF);

    // Store then load.
    run_txn("st10", 1'b1, 1'b1, 32'h10, 32'h12345678, 1'b0, 32'h0);
    chk32("st10_we_cycles", 32'(last_we), 32'd1);
    chk32("st10_mem", mem[4], 32'h12345678);
    run_txn("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h12345678);

    // Contention: both requests held for ten grants.
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4) push_exp(1'b0, 1'b0, 32'hDEADBEEF);
      else              push_exp(1'b1, 1'b0, 32'h12345678);
    end
    if_req = 1'b1; if_addr = 32'h0C;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10;
    for (int i = 0; i < 10; i++) begin
      wait_resp("cont");
      chk32("cont_spacing", 32'(last_cyc), (i == 0) ? 32'd2 : 32'd3);
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    chk32("cont_sb_drained", 32'(sb.size()), 32'd0);

    // Faulted accesses.
    run_txn("st11", 1'b1, 1'b1, 32'h11, 32'hCAFEF00D, 1'b1, 32'h0);
    chk32("st11_we_cycles", 32'(last_we), 32'd0);
    chk32("st11_word4", mem[4], 32'h12345678);
    run_txn("f100", 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0);

    // Reset in the middle of a store's ACCESS cycle.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk1("rs_we_before", mem_we, 1'b1);
    #2 rst = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0;
    #1;
    chk1("rs_we_async", mem_we, 1'b0);
    chk1("rs_busy_async", busy, 1'b0);
    chk32("rs_addr_async", mem_addr, 32'h0);
    chk32("rs_wdata_async", mem_wdata, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("rs_no_dm_ack", dm_ack, 1'b0);
      chk1("rs_busy_low", busy, 1'b0);
    end
    chk32("rs_word8", mem[8], init_word(8));
    chk32("rs_dm_rdata", dm_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    run_txn("st20", 1'b1, 1'b1, 32'h20, 32'hBAD0BAD0, 1'b0, 32'h0);
    chk32("st20_we_cycles", 32'(last_we), 32'd1);
    chk32("st20_mem", mem[8], 32'hBAD0BAD0);
    run_txn("ld20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'hBAD0BAD0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
